lcd1602_responder: RTL and testbench

- Synthesizable HD44780/LCD1602-compatible responder: the display side of the rs/rw/enable/data bus that our LCD driver initiates.
- Decodes commands and data writes, maintains DDRAM (80 B) and CGRAM (64 B), an address counter and display-control state.
- Exposes a render read port for an on-chip display emulator (VGA/char renderer) and a bench-side monitor.
- Sits between the LCD driver outputs and the renderer; the LCD driver needs no modification to target it.

---
 rtl/lcd1602_responder.sv | 210 +++++++++++++++++++++
 tb/tb_lcd1602_responder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_responder.sv
// HD44780/LCD1602-compatible display-side responder: decodes the rs/rw/e bus and keeps
// DDRAM, CGRAM, the address counter and display-control state, with a free-running render port.
module lcd1602_responder #(
  parameter int unsigned BUSY_CYCLES = 40,
  parameter logic [7:0]  CLEAR_FILL  = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe,
  input  logic [6:0] disp_addr,
  output logic [7:0] disp_char,
  input  logic [5:0] cg_addr,
  output logic [4:0] cg_row,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic [6:0] cursor_pos,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR, S_WAIT} state_t;

  localparam int unsigned DDRAM_CELLS = 80;

  state_t      state;
  logic [15:0] cnt;
  logic [6:0]  ac;
  logic        target_cg;
  logic        inc;
  logic        cmd_rs;
  logic [7:0]  cmd_data;

  logic       e_meta, e_sync, e_prev;
  logic       rs_meta, rs_sync, rs_prev;
  logic       rw_meta, rw_sync, rw_prev;
  logic [7:0] data_meta, data_sync, data_prev;
  logic       strobe, read_step;

  logic [7:0] ddram [DDRAM_CELLS];
  logic [7:0] cgram [64];
  logic       dd_we, cg_we;
  logic [6:0] dd_waddr;
  logic [7:0] dd_wdata;
  logic [6:0] ac_lin;
  logic [7:0] rd_byte;

  function automatic logic [6:0] dd_linear(input logic [6:0] a);
    return (a[6] ? 7'd40 : 7'd0) + {1'b0, a[5:0]};
  endfunction

  // DDRAM addresses skip the 0x28-0x3F and 0x68-0x7F holes between the two lines.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic cg, input logic up);
    if (cg) return {1'b0, (up ? a[5:0] + 6'd1 : a[5:0] - 6'd1)};
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  function automatic logic [6:0] dd_clamp(input logic [6:0] a);
    return (a[5:0] > 6'h27) ? {a[6], 6'd0} : a;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {e_meta, e_sync, e_prev}    <= '0;
      {rs_meta, rs_sync, rs_prev} <= '0;
      {rw_meta, rw_sync, rw_prev} <= '0;
      data_meta <= '0;
      data_sync <= '0;
      data_prev <= '0;
    end else begin
      e_meta    <= lcd_e;      e_sync    <= e_meta;    e_prev    <= e_sync;
      rs_meta   <= lcd_rs;     rs_sync   <= rs_meta;   rs_prev   <= rs_sync;
      rw_meta   <= lcd_rw;     rw_sync   <= rw_meta;   rw_prev   <= rw_sync;
      data_meta <= lcd_data_i; data_sync <= data_meta; data_prev <= data_sync;
    end
  end

  // The *_prev copies hold the bus as it was while E was still high.
  assign strobe    = e_prev & ~e_sync;
  assign read_step = strobe & rw_prev & rs_prev;
  assign busy      = (state != S_IDLE);
  assign ac_lin    = dd_linear(ac);
  assign rd_byte   = target_cg ? cgram[ac[5:0]] : ddram[ac_lin];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dd_we    = 1'b0;
    cg_we    = 1'b0;
    dd_waddr = ac_lin;
    dd_wdata = cmd_data;
    if (state == S_EXEC) begin
      if (!cmd_rs && cmd_data == 8'h01) begin
        dd_we    = 1'b1;
        dd_waddr = 7'd0;
        dd_wdata = CLEAR_FILL;
      end else if (cmd_rs) begin
        dd_we = ~target_cg;
        cg_we = target_cg;
      end
    end else if (state == S_CLEAR) begin
      dd_we    = 1'b1;
      dd_waddr = cnt[6:0];
      dd_wdata = CLEAR_FILL;
    end
  end

  // NOTE: RAM arrays are deliberately left without reset so they map onto plain memories.
  always_ff @(posedge clk) begin
    if (dd_we) ddram[dd_waddr] <= dd_wdata;
    if (cg_we) cgram[ac[5:0]]  <= cmd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_char <= '0;
      cg_row    <= '0;
    end else begin
      disp_char <= (disp_addr < 7'd80) ? ddram[disp_addr] : 8'h00;
      cg_row    <= cgram[cg_addr][4:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ac          <= '0;
      target_cg   <= 1'b0;
      inc         <= 1'b1;
      cmd_rs      <= 1'b0;
      cmd_data    <= '0;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      two_line    <= 1'b0;
      cursor_pos  <= '0;
      overrun     <= 1'b0;
      lcd_data_o  <= '0;
      lcd_data_oe <= 1'b0;
    end else begin
      lcd_data_oe <= e_sync & rw_sync;
      if (e_sync && rw_sync) lcd_data_o <= rs_sync ? rd_byte : {busy, ac};
      if (!target_cg) cursor_pos <= ac_lin;
      if (strobe && !rw_prev && busy) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (strobe && !rw_prev) begin
            cmd_rs   <= rs_prev;
            cmd_data <= data_prev;
            state    <= S_EXEC;
          end else if (read_step) begin
            ac <= ac_step(ac, target_cg, inc);
          end
        end
        S_EXEC: begin
          // EXEC is the first busy cycle; for Clear it also writes cell 0.
          cnt   <= 16'd1;
          state <= (BUSY_CYCLES > 1) ? S_WAIT : S_IDLE;
          if (cmd_rs) begin
            ac <= ac_step(ac, target_cg, inc);
          end else begin
            casez (cmd_data)
              8'b1???????: begin ac <= dd_clamp(cmd_data[6:0]); target_cg <= 1'b0; end
              8'b01??????: begin ac <= {1'b0, cmd_data[5:0]}; target_cg <= 1'b1; end
              8'b001?????: two_line <= cmd_data[3];
              8'b0001????: if (!cmd_data[3]) ac <= ac_step(ac, target_cg, cmd_data[2]);
              8'b00001???: {display_on, cursor_on, blink_on} <= cmd_data[2:0];
              8'b000001??: inc <= cmd_data[1];
              8'b0000001?: begin ac <= '0; target_cg <= 1'b0; end
              8'b00000001: begin
                ac        <= '0;
                target_cg <= 1'b0;
                inc       <= 1'b1;
                state     <= S_CLEAR;
              end
              default: ;
            endcase
          end
        end
        S_CLEAR: begin
          if (read_step) ac <= ac_step(ac, target_cg, inc);
          if (cnt == 16'(DDRAM_CELLS - 1)) state <= S_IDLE;
          else cnt <= cnt + 16'd1;
        end
        S_WAIT: begin
          if (read_step) ac <= ac_step(ac, target_cg, inc);
          if (cnt == 16'(BUSY_CYCLES - 1)) state <= S_IDLE;
          else cnt <= cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd1602_responder.sv
// Randomized bench for lcd1602_responder: drives the LCD bus, keeps a linear-index model of
// the display and compares every settled cycle, plus literal checks from the bring-up sequence.
module tb_lcd1602_responder;

  localparam int         BUSY = 40;
  localparam logic [7:0] FILL = 8'h20;
  localparam int         HI   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data_i, lcd_data_o;
  logic       lcd_data_oe;
  logic [6:0] disp_addr;
  logic [7:0] disp_char;
  logic [5:0] cg_addr;
  logic [4:0] cg_row;
  logic       display_on, cursor_on, blink_on, two_line;
  logic [6:0] cursor_pos;
  logic       busy, overrun;

  lcd1602_responder #(.BUSY_CYCLES(BUSY), .CLEAR_FILL(FILL)) dut (
    .clk(clk), .reset(reset),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data_i(lcd_data_i), .lcd_data_o(lcd_data_o), .lcd_data_oe(lcd_data_oe),
    .disp_addr(disp_addr), .disp_char(disp_char),
    .cg_addr(cg_addr), .cg_row(cg_row),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .cursor_pos(cursor_pos), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the DDRAM cursor is a plain linear index 0..79 that wraps modulo 80.
  logic [7:0] m_dd [80];
  bit         m_dd_known [80];
  logic [7:0] m_cg [64];
  bit         m_cg_known [64];
  int         m_idx, m_cg_ac;
  bit         m_cg_target, m_inc, m_disp, m_cur, m_blink, m_two, m_ovr;
  bit         quiet;
  logic [7:0] seen_dd [80];
  logic [4:0] seen_cg [64];

  function automatic void model_reset();
    m_idx = 0; m_cg_ac = 0; m_cg_target = 0; m_inc = 1;
    m_disp = 0; m_cur = 0; m_blink = 0; m_two = 0; m_ovr = 0;
  endfunction

  function automatic void model_step(input bit up);
    if (m_cg_target) m_cg_ac = (m_cg_ac + (up ? 1 : 63)) % 64;
    else             m_idx   = (m_idx + (up ? 1 : 79)) % 80;
  endfunction

  function automatic logic [7:0] model_ac();
    if (m_cg_target) return 8'(m_cg_ac);
    return (m_idx >= 40) ? 8'(8'h40 + m_idx - 40) : 8'(m_idx);
  endfunction

  function automatic void model_write(input bit rs, input logic [7:0] d);
    int col;
    if (rs) begin
      if (m_cg_target) begin m_cg[m_cg_ac] = d; m_cg_known[m_cg_ac] = 1; end
      else             begin m_dd[m_idx] = d;   m_dd_known[m_idx] = 1;   end
      model_step(m_inc);
    end else if (d[7]) begin
      col = int'(d[5:0]);
      m_cg_target = 0;
      m_idx = (d[6] ? 40 : 0) + ((col > 39) ? 0 : col);
    end else if (d[6]) begin
      m_cg_target = 1; m_cg_ac = int'(d[5:0]);
    end else if (d[5]) begin
      m_two = d[3];
    end else if (d[4]) begin
      if (!d[3]) model_step(d[2]);
    end else if (d[3]) begin
      m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
    end else if (d[2]) begin
      m_inc = d[1];
    end else if (d[1]) begin
      m_idx = 0; m_cg_target = 0;
    end else if (d[0]) begin
      for (int i = 0; i < 80; i++) begin m_dd[i] = FILL; m_dd_known[i] = 1; end
      m_idx = 0; m_cg_target = 0; m_inc = 1;
    end
  endfunction

  // Render scanner and compare process: sweeps both render ports and checks on settled cycles.
  initial begin : scanner
    int pa, pc;
    pa = 0; pc = 0;
    disp_addr = '0; cg_addr = '0;
    forever begin
      @(negedge clk);
      seen_dd[pa] = disp_char;
      seen_cg[pc] = cg_row;
      if (quiet) begin
        check("display_on", display_on, m_disp);
        check("cursor_on", cursor_on, m_cur);
        check("blink_on", blink_on, m_blink);
        check("two_line", two_line, m_two);
        check("cursor_pos", cursor_pos, m_idx);
        check("overrun", overrun, m_ovr);
        check("busy_idle", busy, 0);
        check("oe_idle", lcd_data_oe, 0);
        if (m_dd_known[pa]) check("disp_char", disp_char, m_dd[pa]);
        if (m_cg_known[pc]) check("cg_row", cg_row, m_cg[pc][4:0]);
      end
      pa = (pa + 1) % 80;
      pc = (pc + 1) % 64;
      disp_addr = 7'(pa);
      cg_addr   = 6'(pc);
    end
  end

  task automatic strobe_bus(input bit rs, input bit rw, input logic [7:0] d, input int hi);
    lcd_rs = rs; lcd_rw = rw; lcd_data_i = d;
    repeat (2) @(negedge clk);
    lcd_e = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_e = 1'b0;
  endtask

  task automatic wait_rise(output bit rose);
    int t;
    t = 0;
    while (!busy && t < 12) begin @(negedge clk); t++; end
    rose = busy;
  endtask

  task automatic wait_fall();
    int t;
    t = 0;
    while (busy && t < 400) begin @(negedge clk); t++; end
    check("busy_fall_timeout", busy, 0);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    quiet = 1;
  endtask

  task automatic write_bus(input bit rs, input logic [7:0] d, input int hi);
    int n;
    bit rose;
    quiet = 0;
    strobe_bus(rs, 1'b0, d, hi);
    model_write(rs, d);
    wait_rise(rose);
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    check(rs ? "data_busy_len" : "cmd_busy_len", n, (!rs && d == 8'h01) ? 80 : BUSY);
    settle();
  endtask

  task automatic read_bus(input bit rs, input int hi, output logic [7:0] v);
    logic [7:0] exp;
    bit         known;
    quiet = 0;
    if (!rs)              begin exp = model_ac();      known = 1; end
    else if (m_cg_target) begin exp = m_cg[m_cg_ac];   known = m_cg_known[m_cg_ac]; end
    else                  begin exp = m_dd[m_idx];     known = m_dd_known[m_idx]; end
    strobe_bus(rs, 1'b1, 8'h00, hi - 1);
    v = lcd_data_o;
    check("read_oe", lcd_data_oe, 1);
    if (known) check(rs ? "read_data" : "read_ac", v, exp);
    if (rs) model_step(m_inc);
    repeat (6) @(negedge clk);
    settle();
  endtask

  task automatic sweep();
    repeat (82) @(negedge clk);
  endtask

  task automatic random_ops(input int count);
    logic [7:0] r8, v;
    int r;
    for (int i = 0; i < count; i++) begin
      r  = $urandom_range(0, 99);
      r8 = 8'($urandom);
      if (r < 40)      write_bus(1'b1, r8, $urandom_range(4, 8));
      else if (r < 48) read_bus(1'b1, $urandom_range(4, 8), v);
      else if (r < 53) read_bus(1'b0, $urandom_range(4, 8), v);
      else if (r < 56) write_bus(1'b0, 8'h01, 6);
      else begin
        case ($urandom_range(0, 6))
          0: r8 = 8'h02 | (r8 & 8'h01);
          1: r8 = 8'h04 | (r8 & 8'h03);
          2: r8 = 8'h08 | (r8 & 8'h07);
          3: r8 = 8'h10 | (r8 & 8'h0F);
          4: r8 = 8'h20 | (r8 & 8'h1F);
          5: r8 = 8'h40 | (r8 & 8'h3F);
          default: r8 = 8'h80 | (r8 & 8'h7F);
        endcase
        write_bus(1'b0, r8, $urandom_range(4, 8));
      end
    end
  endtask

  initial begin : main
    logic [7:0] v;
    bit rose;
    reset = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_i = '0;
    quiet = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_display_on", display_on, 0);
    check("rst_two_line", two_line, 0);
    check("rst_cursor_pos", cursor_pos, 0);
    check("rst_data_o", lcd_data_o, 0);
    check("rst_data_oe", lcd_data_oe, 0);
    check("rst_disp_char", disp_char, 0);
    check("rst_cg_row", cg_row, 0);
    reset = 1'b0;
    settle();

    // Bring-up: function set, display on, clear.
    write_bus(1'b0, 8'h38, HI);
    write_bus(1'b0, 8'h0C, HI);
    write_bus(1'b0, 8'h01, HI);
    check("p1_two_line", two_line, 1);
    check("p1_display_on", display_on, 1);
    check("p1_cursor_on", cursor_on, 0);
    sweep();
    for (int i = 0; i < 80; i++) check("p1_clear_cell", seen_dd[i], 8'h20);

    // CGRAM glyph rows.
    write_bus(1'b0, 8'h40, HI);
    for (int i = 1; i <= 8; i++) write_bus(1'b1, 8'(i), HI);
    write_bus(1'b0, 8'h48, HI);
    write_bus(1'b1, 8'h1F, HI);
    sweep();
    for (int i = 0; i < 8; i++) check("p2_cg_row", seen_cg[i], 5'(i + 1));
    check("p2_cg_row8", seen_cg[8], 5'h1F);

    // Two lines of DDRAM data.
    write_bus(1'b0, 8'h80, HI);
    for (int i = 0; i < 3; i++) write_bus(1'b1, 8'(i), HI);
    write_bus(1'b0, 8'hC0, HI);
    for (int i = 3; i < 6; i++) write_bus(1'b1, 8'(i), HI);
    sweep();
    check("p3_dd0", seen_dd[0], 8'h00);
    check("p3_dd2", seen_dd[2], 8'h02);
    check("p3_dd40", seen_dd[40], 8'h03);
    check("p3_dd42", seen_dd[42], 8'h05);
    check("p3_cursor_pos", cursor_pos, 43);

    // Line-end wrap 0x27 -> 0x40.
    write_bus(1'b0, 8'hA7, HI);
    write_bus(1'b1, 8'h41, HI);
    write_bus(1'b1, 8'h42, HI);
    sweep();
    check("p4_dd39", seen_dd[39], 8'h41);
    check("p4_dd40", seen_dd[40], 8'h42);
    read_bus(1'b0, HI, v);
    check("p4_ac_readback", v, 8'h41);

    // Write while busy is dropped and flags overrun.
    quiet = 0;
    strobe_bus(1'b0, 1'b0, 8'h0F, HI);
    model_write(1'b0, 8'h0F);
    wait_rise(rose);
    check("p5_busy_rise", rose, 1);
    repeat (2) @(negedge clk);
    strobe_bus(1'b0, 1'b0, 8'h0E, HI);
    m_ovr = 1;
    repeat (4) @(negedge clk);
    wait_fall();
    settle();
    check("p5_blink_on", blink_on, 1);
    check("p5_overrun", overrun, 1);

    random_ops(200);

    // Known fill pattern, then reset part-way through a clear.
    write_bus(1'b0, 8'h06, 8);
    write_bus(1'b0, 8'h80, 8);
    for (int i = 0; i < 80; i++) write_bus(1'b1, 8'(i) ^ 8'h5A, 6);
    quiet = 0;
    strobe_bus(1'b0, 1'b0, 8'h01, HI);
    wait_rise(rose);
    check("p6_busy_rise", rose, 1);
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 30; i++) m_dd[i] = FILL;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    settle();
    check("p6_busy", busy, 0);
    check("p6_display_on", display_on, 0);
    check("p6_cursor_pos", cursor_pos, 0);
    check("p6_overrun", overrun, 0);
    sweep();
    for (int i = 0; i < 30; i++) check("p6_cleared_cell", seen_dd[i], 8'h20);
    for (int i = 30; i < 80; i++) check("p6_kept_cell", seen_dd[i], 8'(i) ^ 8'h5A);

    random_ops(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
